// File: rtl/watch_pkg.sv
// Shared types and helpers for the watch display path.
package watch_pkg;

    localparam int SEG_W = 7;
    localparam int NDIG  = 4;

    typedef logic [SEG_W-1:0] seg_t;
    typedef logic [1:0]       dig_idx_t;
    typedef logic [1:0]       bright_t;

    // Lit length of a slot for brightness b (0..3), in clock cycles.
    function automatic int on_len(input int scan_div, input int blank_cyc, input int b);
        return ((scan_div - blank_cyc) * (b + 1)) / 4;
    endfunction

endpackage

// File: rtl/watch_scan_cnt.sv
// Slot counter, digit index and end-of-frame pulse for the display scanner.
module watch_scan_cnt
    import watch_pkg::*;
#(
    parameter  int SCAN_DIV = 64,
    localparam int CNT_W    = $clog2(SCAN_DIV)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output dig_idx_t         idx_o,
    output logic             frame_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    dig_idx_t         idx_q, idx_d;
    logic             frame_q, frame_d;

    always_comb begin
        cnt_d   = '0;
        idx_d   = '0;
        frame_d = 1'b0;
        if (en_i) begin
            frame_d = (idx_q == 2'd3) && (cnt_q == CNT_MAX);
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                idx_d = idx_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                idx_d = idx_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign idx_o   = idx_q;
    assign frame_o = frame_q;

endmodule

// File: rtl/watch_disp_scan.sv
// Multiplexed 4-digit LED scanner: per-frame segment snapshot, per-slot
// brightness via lit-window length, registered digit/segment drive.
module watch_disp_scan
    import watch_pkg::*;
#(
    parameter int SCAN_DIV  = 64,
    parameter int BLANK_CYC = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  seg_t            segment_hxxx_i,
    input  seg_t            segment_xhxx_i,
    input  seg_t            segment_xxmx_i,
    input  seg_t            segment_xxxm_i,
    input  bright_t         bright_i,
    output seg_t            seg_o,
    output logic [NDIG-1:0] dig_o,
    output logic            frame_o
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    // Slot-relative end points of the BLANK and ON phases, one bit wider than
    // cnt because the full-brightness ON phase ends exactly at SCAN_DIV.
    localparam logic [CNT_W:0] BLANK_END = (CNT_W+1)'(BLANK_CYC);
    localparam logic [CNT_W:0] ON_END0   = (CNT_W+1)'(BLANK_CYC + on_len(SCAN_DIV, BLANK_CYC, 0));
    localparam logic [CNT_W:0] ON_END1   = (CNT_W+1)'(BLANK_CYC + on_len(SCAN_DIV, BLANK_CYC, 1));
    localparam logic [CNT_W:0] ON_END2   = (CNT_W+1)'(BLANK_CYC + on_len(SCAN_DIV, BLANK_CYC, 2));
    localparam logic [CNT_W:0] ON_END3   = (CNT_W+1)'(BLANK_CYC + on_len(SCAN_DIV, BLANK_CYC, 3));

    logic [CNT_W-1:0] cnt;
    dig_idx_t         idx;

    seg_t             snap_q [NDIG];
    seg_t             snap_d [NDIG];
    bright_t          bright_q, bright_d;
    seg_t             seg_q, seg_d;
    logic [NDIG-1:0]  dig_q, dig_d;
    logic [CNT_W:0]   on_end;
    logic [CNT_W:0]   cnt_x;
    logic             lit;

    watch_scan_cnt #(
        .SCAN_DIV (SCAN_DIV)
    ) u_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (en_i),
        .cnt_o   (cnt),
        .idx_o   (idx),
        .frame_o (frame_o)
    );

    always_comb begin
        snap_d   = snap_q;
        bright_d = bright_q;
        seg_d    = '0;
        dig_d    = '0;
        cnt_x    = {1'b0, cnt};

        case (bright_q)
            2'd0:    on_end = ON_END0;
            2'd1:    on_end = ON_END1;
            2'd2:    on_end = ON_END2;
            default: on_end = ON_END3;
        endcase
        lit = (cnt_x >= BLANK_END) && (cnt_x < on_end);

        if (en_i) begin
            if (cnt == '0) begin
                bright_d = bright_i;
                if (idx == 2'd0) begin
                    snap_d[0] = segment_hxxx_i;
                    snap_d[1] = segment_xhxx_i;
                    snap_d[2] = segment_xxmx_i;
                    snap_d[3] = segment_xxxm_i;
                end
            end
            // cnt=0 is always blank, so the snapshot/brightness taken there
            // never races with the lit decode that reads the held copies.
            if (lit) begin
                dig_d = 4'b1000 >> idx;
                seg_d = snap_q[idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NDIG; i++) snap_q[i] <= '0;
            bright_q <= '0;
            seg_q    <= '0;
            dig_q    <= '0;
        end else begin
            snap_q   <= snap_d;
            bright_q <= bright_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
        end
    end

    assign seg_o = seg_q;
    assign dig_o = dig_q;

endmodule

// File: tb/tb_watch_disp_scan.sv
// Bench for watch_disp_scan: elapsed-time model for a default and a small
// instance, checked every cycle, plus directed literal checkpoints.
module tb_watch_disp_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [6:0] s_h = 7'h00, s_xh = 7'h00, s_xm = 7'h00, s_xxm = 7'h00;
    logic [1:0] bright = 2'd0;

    logic [6:0] seg0, seg1;
    logic [3:0] dig0, dig1;
    logic       frm0, frm1;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    watch_disp_scan dut (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .segment_hxxx_i(s_h), .segment_xhxx_i(s_xh),
        .segment_xxmx_i(s_xm), .segment_xxxm_i(s_xxm),
        .bright_i(bright), .seg_o(seg0), .dig_o(dig0), .frame_o(frm0)
    );

    watch_disp_scan #(.SCAN_DIV(8), .BLANK_CYC(1)) dut_s (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .segment_hxxx_i(s_h), .segment_xhxx_i(s_xh),
        .segment_xxmx_i(s_xm), .segment_xxxm_i(s_xxm),
        .bright_i(bright), .seg_o(seg1), .dig_o(dig1), .frame_o(frm1)
    );

    // Model state per instance: t = enabled edges since restart.
    int         t_m  [2] = '{0, 0};
    int         bs_m [2] = '{0, 0};
    logic [6:0] snap_m [2][4];
    logic [6:0] exp_seg [2] = '{7'h0, 7'h0};
    logic [3:0] exp_dig [2] = '{4'h0, 4'h0};
    logic       exp_frm [2] = '{1'b0, 1'b0};

    task automatic model_step(input int k, input int sd, input int bc);
        int cnt, idx, ol;
        if (rst) begin
            t_m[k] = 0;
            bs_m[k] = 0;
            for (int i = 0; i < 4; i++) snap_m[k][i] = 7'h0;
            exp_seg[k] = 7'h0; exp_dig[k] = 4'h0; exp_frm[k] = 1'b0;
        end else if (!en) begin
            t_m[k] = 0;
            exp_seg[k] = 7'h0; exp_dig[k] = 4'h0; exp_frm[k] = 1'b0;
        end else begin
            cnt = t_m[k] % sd;
            idx = (t_m[k] / sd) % 4;
            if (cnt == 0) bs_m[k] = int'(bright);
            if (cnt == 0 && idx == 0) begin
                snap_m[k][0] = s_h;  snap_m[k][1] = s_xh;
                snap_m[k][2] = s_xm; snap_m[k][3] = s_xxm;
            end
            ol = ((sd - bc) * (bs_m[k] + 1)) / 4;
            exp_dig[k] = 4'h0;
            exp_seg[k] = 7'h0;
            if (cnt >= bc && cnt < bc + ol) begin
                exp_dig[k][3-idx] = 1'b1;
                exp_seg[k] = snap_m[k][idx];
            end
            exp_frm[k] = (idx == 3) && (cnt == sd - 1);
            t_m[k]++;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 64, 4);
        model_step(1, 8, 1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("m0_seg", 32'(seg0), 32'(exp_seg[0]));
            check("m0_dig", 32'(dig0), 32'(exp_dig[0]));
            check("m0_frm", 32'(frm0), 32'(exp_frm[0]));
            check("m1_seg", 32'(seg1), 32'(exp_seg[1]));
            check("m1_dig", 32'(dig1), 32'(exp_dig[1]));
            check("m1_frm", 32'(frm1), 32'(exp_frm[1]));
            check("onehot0", 32'($countones(dig0) <= 1), 32'd1);
            check("onehot1", 32'($countones(dig1) <= 1), 32'd1);
            check("darkseg0", 32'(dig0 != 4'h0 || seg0 == 7'h0), 32'd1);
            check("darkseg1", 32'(dig1 != 4'h0 || seg1 == 7'h0), 32'd1);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int lit;
    int fr_first, fr_second;

    initial begin
        // Reset with enable low.
        step(3);
        chk_on = 1'b1;
        check("rst_dig", 32'(dig0), 32'h0);
        check("rst_seg", 32'(seg0), 32'h0);
        check("rst_frm", 32'(frm0), 32'h0);

        // Full brightness frame.
        s_h = 7'h06; s_xh = 7'h5B; s_xm = 7'h4F; s_xxm = 7'h66;
        bright = 2'd3;
        rst = 1'b0; en = 1'b1;
        step(4);
        check("blank4_dig", 32'(dig0), 32'h0);
        step(1);
        check("on_dig", 32'(dig0), 32'h8);
        check("on_seg", 32'(seg0), 32'h06);
        step(59);
        check("on_last_dig", 32'(dig0), 32'h8);
        step(1);
        check("slot1_blank", 32'(dig0), 32'h0);
        step(4);
        check("d1_dig", 32'(dig0), 32'h4);
        check("d1_seg", 32'(seg0), 32'h5B);
        step(186);
        check("frame_pre", 32'(frm0), 32'h0);
        step(1);
        check("frame_pulse", 32'(frm0), 32'h1);

        // Dimmest: 15 lit cycles per digit.
        bright = 2'd0;
        lit = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (dig0 == 4'b1000) lit++;
        end
        check("dim_lit", 32'(lit), 32'd15);

        // Mid-frame input change shows only in the next frame.
        step(70);
        s_xm = 7'h7F;
        step(64);
        check("snap_old_dig", 32'(dig0), 32'h2);
        check("snap_old_seg", 32'(seg0), 32'h4F);
        step(255);
        check("snap_new_seg", 32'(seg0), 32'h7F);

        // Enable dropped mid-ON for 10 cycles.
        bright = 2'd3;
        en = 1'b0;
        step(1);
        check("dis_dig", 32'(dig0), 32'h0);
        check("dis_seg", 32'(seg0), 32'h0);
        step(9);
        en = 1'b1;
        step(4);
        check("reen_blank", 32'(dig0), 32'h0);
        step(1);
        check("reen_dig", 32'(dig0), 32'h8);
        check("reen_seg", 32'(seg0), 32'h06);

        // One-cycle reset at idx=2, cnt=30.
        step(153);
        check("pre_rst_dig", 32'(dig0), 32'h2);
        check("pre_rst_seg", 32'(seg0), 32'h7F);
        rst = 1'b1;
        step(1);
        check("mid_rst_dig", 32'(dig0), 32'h0);
        check("mid_rst_seg", 32'(seg0), 32'h0);
        rst = 1'b0;
        step(4);
        check("post_rst_blank", 32'(dig0), 32'h0);
        step(1);
        check("post_rst_dig", 32'(dig0), 32'h8);
        check("post_rst_seg", 32'(seg0), 32'h06);

        // Small instance: ON_LEN=3, frame every 32 cycles.
        bright = 2'd1;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        lit = 0;
        fr_first = -1;
        fr_second = -1;
        for (int k = 1; k <= 64; k++) begin
            step(1);
            if (k <= 32 && dig1 == 4'b1000) lit++;
            if (frm1) begin
                if (fr_first < 0) fr_first = k;
                else if (fr_second < 0) fr_second = k;
            end
        end
        check("small_lit", 32'(lit), 32'd3);
        check("small_frame1", 32'(fr_first), 32'd32);
        check("small_period", 32'(fr_second - fr_first), 32'd32);

        step(2);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/watch_disp_scan.md
WATCH_DISP_SCAN -- requirements
Module: watch_disp_scan

Interface
REQ-001 Parameter SCAN_DIV, default 64, clock cycles per digit slot; legal range 8..1024.
REQ-002 Parameter BLANK_CYC, default 4, blanking cycles at the start of each slot; legal range 1..SCAN_DIV/2-1.
REQ-003 clk_i  in  1  32.768 kHz clock; the only clock in the block.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 en_i  in  1  scan enable.
REQ-006 segment_hxxx_i, segment_xhxx_i, segment_xxmx_i, segment_xxxm_i  in  7 each  segment patterns from watch_hhmm, hours-tens to minutes-units.
REQ-007 bright_i  in  2  brightness level, 0 = dimmest, 3 = full.
REQ-008 seg_o  out  7  shared segment bus, active-high.
REQ-009 dig_o  out  4  digit enables, one-hot or zero; dig_o[3] = hxxx through dig_o[0] = xxxm.
REQ-010 frame_o  out  1  single-cycle pulse at the end of each 4-digit frame.

Function
REQ-011 Slot counter cnt SHALL run 0..SCAN_DIV-1 and wrap to 0.
REQ-012 Digit index idx SHALL advance 0->1->2->3->0 on the cnt wrap; idx0=hxxx, idx1=xhxx, idx2=xxmx, idx3=xxxm.
REQ-013 At idx=0, cnt=0, the block SHALL capture all four segment inputs into a snapshot; inputs changing mid-frame SHALL NOT be visible until the next frame.
REQ-014 bright_i SHALL be sampled at cnt=0 of every slot; changes mid-slot take effect in the next slot.
REQ-015 Slot phases: BLANK for cnt < BLANK_CYC; ON for BLANK_CYC <= cnt < BLANK_CYC+ON_LEN; OFF for the rest of the slot.
REQ-016 ON_LEN = ((SCAN_DIV-BLANK_CYC)*(b+1))/4 using integer division, where b is the sampled brightness; with default parameters ON_LEN = 15/30/45/60 for b = 0/1/2/3.
REQ-017 In ON, dig_o = the one-hot code for idx and seg_o = snapshot[idx].
REQ-018 In BLANK and OFF, dig_o = 0 and seg_o = 0.
REQ-019 frame_o SHALL assert for exactly the cycle corresponding to idx=3, cnt=SCAN_DIV-1.
REQ-020 All outputs SHALL be registered, with 1-cycle latency from the counter state they reflect.
REQ-021 dig_o SHALL never have more than one bit set.
REQ-022 seg_o SHALL be 0 whenever dig_o = 0.
REQ-023 en_i=0: cnt, idx and all outputs are forced to 0 at the next edge; the snapshot is held.
REQ-024 en_i 0->1: the scan restarts at idx=0, cnt=0 with a fresh snapshot capture.
REQ-025 When rst_i and en_i are both active, rst_i dominates.

Reset
REQ-026 While rst_i=1 at a clock edge: cnt, idx, snapshot, sampled brightness, seg_o, dig_o and frame_o all SHALL clear to 0.
REQ-027 The first edge with rst_i=0 and en_i=1 is idx=0, cnt=0, and a snapshot capture occurs there.
REQ-028 Reset asserted mid-slot SHALL blank the outputs one edge later, with no partial-slot remnant after release.

Structure
REQ-029 Shared package watch_pkg SHALL hold: SEG_W=7, NDIG=4, typedef seg_t (7 bit), typedef dig_idx_t (2 bit), typedef bright_t (2 bit).
REQ-030 One sub-module, watch_scan_cnt, SHALL contain cnt, idx and the frame_o pulse.
REQ-031 Phase decode, snapshot and output registers SHALL live in the top level.
REQ-032 No latches and no clock gating are permitted.

Verification
REQ-033 Reset, then en_i=1, bright_i=3, inputs 7'h06/7'h5B/7'h4F/7'h66 -> after 4 blank cycles: dig_o=4'b1000 with seg_o=7'h06 for 60 cycles, 0 for 4 cycles, then 4'b0100 with seg_o=7'h5B, and so on; frame_o pulses every 256 cycles.
REQ-034 bright_i=0 -> each digit is lit for 15 of 64 cycles; one-hot and zero-seg-when-dark assertions hold throughout.
REQ-035 Change segment_xxmx_i during idx=1 -> slot idx2 shows the old value; the new value appears in the next frame.
REQ-036 Drop en_i mid-ON for 10 cycles, then raise it -> outputs are 0 within 1 edge; on re-enable the scan resumes at dig_o=4'b1000 after 4 blank cycles.
REQ-037 Assert rst_i for 1 cycle at idx=2, cnt=30 -> all outputs 0 next edge; the restart timing matches REQ-033.
REQ-038 Run with SCAN_DIV=8, BLANK_CYC=1, bright_i=1 -> ON_LEN=3; frame_o period is 32 cycles.
